// File: rtl/fsub_halfprecision_seq_pkg.sv
// Shared widths, limits and FSM encoding for the half-precision subtractor.
package fsub_halfprecision_seq_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int SIG_W = MAN_W + 1;
  localparam int RES_W = MAN_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'b11111;
  localparam logic [EXP_W-1:0] EXP_TOP = 5'b11110;
  localparam logic [3:0]       ALIGN_CAP = 4'd11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ALIGN = 3'd1,
    ST_ARITH = 3'd2,
    ST_NORM  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Beyond 11 shifts the smaller significand is already all zeros.
  function automatic logic [3:0] align_count(input logic [EXP_W-1:0] diff);
    if (diff > EXP_W'(ALIGN_CAP)) begin
      return ALIGN_CAP;
    end
    return diff[3:0];
  endfunction

endpackage

// File: rtl/fsub_mantissa_alu.sv
// Combinational add/subtract of two 11-bit significands into a 12-bit result.
module fsub_mantissa_alu
  import fsub_halfprecision_seq_pkg::*;
(
  input  logic [SIG_W-1:0] i_a,
  input  logic [SIG_W-1:0] i_b,
  input  logic             i_sub,
  output logic [RES_W-1:0] o_res
);

  always_comb begin
    o_res = '0;
    if (i_sub) begin
      o_res = {1'b0, i_a} - {1'b0, i_b};
    end else begin
      o_res = {1'b0, i_a} + {1'b0, i_b};
    end
  end

endmodule

// File: rtl/fsub_halfprecision_seq.sv
// Multi-cycle half-precision A-B: capture/order, serial align, add/sub, serial normalise.
module fsub_halfprecision_seq
  import fsub_halfprecision_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_Valid,
  input  logic        in_Sign_1,
  input  logic [5:1]  in_Exponent_1,
  input  logic [10:1] in_Mantissa_1,
  input  logic        in_Sign_2,
  input  logic [5:1]  in_Exponent_2,
  input  logic [10:1] in_Mantissa_2,
  output logic        out_Ready,
  output logic        out_Valid,
  output logic        out_Sign,
  output logic [5:1]  out_Exponent,
  output logic [10:1] out_Mantissa
);

  state_t             r_state;
  state_t             w_state_nxt;

  logic               r_sign_l;
  logic               r_sub;
  logic [EXP_W-1:0]   r_exp;
  logic [SIG_W-1:0]   r_man_l;
  logic [SIG_W-1:0]   r_man_s;
  logic [3:0]         r_cnt;
  logic [RES_W-1:0]   r_res;

  logic               r_out_valid;
  logic               r_out_sign;
  logic [EXP_W-1:0]   r_out_exp;
  logic [MAN_W-1:0]   r_out_man;

  logic               w_a_ge_b;
  logic               w_sign_b_eff;
  logic               w_sign_l;
  logic               w_sign_s;
  logic [EXP_W-1:0]   w_exp_l;
  logic [EXP_W-1:0]   w_exp_s;
  logic [MAN_W-1:0]   w_man_l;
  logic [MAN_W-1:0]   w_man_s;
  logic [EXP_W-1:0]   w_diff;
  logic [3:0]         w_cnt0;
  logic [RES_W-1:0]   w_alu_res;
  logic               w_underflow;
  logic               w_overflow;

  // Operand ordering: B enters already negated so the rest is a plain add.
  always_comb begin
    w_sign_b_eff = ~in_Sign_2;
    w_a_ge_b     = {in_Exponent_1, in_Mantissa_1} >= {in_Exponent_2, in_Mantissa_2};
    w_sign_l     = w_a_ge_b ? in_Sign_1     : w_sign_b_eff;
    w_sign_s     = w_a_ge_b ? w_sign_b_eff  : in_Sign_1;
    w_exp_l      = w_a_ge_b ? in_Exponent_1 : in_Exponent_2;
    w_exp_s      = w_a_ge_b ? in_Exponent_2 : in_Exponent_1;
    w_man_l      = w_a_ge_b ? in_Mantissa_1 : in_Mantissa_2;
    w_man_s      = w_a_ge_b ? in_Mantissa_2 : in_Mantissa_1;
    w_diff       = w_exp_l - w_exp_s;
    w_cnt0       = align_count(w_diff);
  end

  fsub_mantissa_alu u_alu (
    .i_a   (r_man_l),
    .i_b   (r_man_s),
    .i_sub (r_sub),
    .o_res (w_alu_res)
  );

  always_comb begin
    w_underflow = (r_exp <= EXP_W'(1));
    w_overflow  = (r_exp >= EXP_TOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_Valid) begin
          w_state_nxt = (w_cnt0 != 4'd0) ? ST_ALIGN : ST_ARITH;
        end
      end
      ST_ALIGN: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = ST_ARITH;
        end
      end
      ST_ARITH: w_state_nxt = ST_NORM;
      ST_NORM: begin
        if (r_res == '0 || r_res[RES_W-1] || r_res[RES_W-2] || w_underflow) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sign_l    <= 1'b0;
      r_sub       <= 1'b0;
      r_exp       <= '0;
      r_man_l     <= '0;
      r_man_s     <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_exp   <= '0;
      r_out_man   <= '0;
    end else begin
      r_out_valid <= (r_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (in_Valid) begin
            r_sign_l <= w_sign_l;
            r_sub    <= (w_sign_l != w_sign_s);
            r_exp    <= w_exp_l;
            r_man_l  <= {1'b1, w_man_l};
            r_man_s  <= {1'b1, w_man_s};
            r_cnt    <= w_cnt0;
          end
        end
        ST_ALIGN: begin
          r_man_s <= r_man_s >> 1;
          r_cnt   <= r_cnt - 4'd1;
        end
        ST_ARITH: begin
          r_res <= w_alu_res;
        end
        ST_NORM: begin
          if (r_res == '0) begin
            r_sign_l <= 1'b0;
            r_exp    <= '0;
          end else if (r_res[RES_W-1]) begin
            if (w_overflow) begin
              r_exp <= EXP_MAX;
              r_res <= '0;
            end else begin
              r_exp <= r_exp + EXP_W'(1);
              r_res <= r_res >> 1;
            end
          end else if (!r_res[RES_W-2]) begin
            // Another left shift would push the exponent to zero: flush.
            if (w_underflow) begin
              r_sign_l <= 1'b0;
              r_exp    <= '0;
              r_res    <= '0;
            end else begin
              r_exp <= r_exp - EXP_W'(1);
              r_res <= r_res << 1;
            end
          end
        end
        ST_DONE: begin
          r_out_sign <= r_sign_l;
          r_out_exp  <= r_exp;
          r_out_man  <= r_res[MAN_W-1:0];
        end
        default: begin
        end
      endcase
    end
  end

  assign out_Ready    = (r_state == ST_IDLE);
  assign out_Valid    = r_out_valid;
  assign out_Sign     = r_out_sign;
  assign out_Exponent = r_out_exp;
  assign out_Mantissa = r_out_man;

endmodule

// File: tb/tb_fsub_halfprecision_seq.sv
// Directed-vector bench for fsub_halfprecision_seq with hand-computed results.
module tb_fsub_halfprecision_seq;

  logic       clk;
  logic       rst;
  logic       in_Valid;
  logic       in_Sign_1;
  logic [4:0] in_Exponent_1;
  logic [9:0] in_Mantissa_1;
  logic       in_Sign_2;
  logic [4:0] in_Exponent_2;
  logic [9:0] in_Mantissa_2;
  logic       out_Ready;
  logic       out_Valid;
  logic       out_Sign;
  logic [4:0] out_Exponent;
  logic [9:0] out_Mantissa;

  int n_checks = 0;
  int n_errors = 0;

  fsub_halfprecision_seq dut (
    .clk           (clk),
    .rst           (rst),
    .in_Valid      (in_Valid),
    .in_Sign_1     (in_Sign_1),
    .in_Exponent_1 (in_Exponent_1),
    .in_Mantissa_1 (in_Mantissa_1),
    .in_Sign_2     (in_Sign_2),
    .in_Exponent_2 (in_Exponent_2),
    .in_Mantissa_2 (in_Mantissa_2),
    .out_Ready     (out_Ready),
    .out_Valid     (out_Valid),
    .out_Sign      (out_Sign),
    .out_Exponent  (out_Exponent),
    .out_Mantissa  (out_Mantissa)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_ops(input logic sa, input logic [4:0] ea, input logic [9:0] ma,
                           input logic sb, input logic [4:0] eb, input logic [9:0] mb);
    in_Sign_1     = sa;
    in_Exponent_1 = ea;
    in_Mantissa_1 = ma;
    in_Sign_2     = sb;
    in_Exponent_2 = eb;
    in_Mantissa_2 = mb;
  endtask

  task automatic check_out(input string tag, input logic es, input logic [4:0] ee,
                           input logic [9:0] em);
    check({tag, ".sign"}, 32'(out_Sign), 32'(es));
    check({tag, ".exp"},  32'(out_Exponent), 32'(ee));
    check({tag, ".man"},  32'(out_Mantissa), 32'(em));
  endtask

  // Accept one operation, then count cycles from the accept edge to out_Valid.
  task automatic run_op(input string tag,
                        input logic sa, input logic [4:0] ea, input logic [9:0] ma,
                        input logic sb, input logic [4:0] eb, input logic [9:0] mb,
                        input logic es, input logic [4:0] ee, input logic [9:0] em,
                        input int lat);
    int n;
    bit seen;
    n = 0;
    while (!out_Ready && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, ".ready"}, 32'(out_Ready), 32'd1);
    drive_ops(sa, ea, ma, sb, eb, mb);
    in_Valid = 1'b1;
    @(posedge clk); #1;
    in_Valid = 1'b0;
    check({tag, ".busy"}, 32'(out_Ready), 32'd0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (out_Valid) seen = 1'b1;
    end
    check({tag, ".seen"}, 32'(seen), 32'd1);
    check({tag, ".lat"}, 32'(n), 32'(lat));
    check_out(tag, es, ee, em);
    @(posedge clk); #1;
    check({tag, ".pulse"}, 32'(out_Valid), 32'd0);
    check_out({tag, ".hold"}, es, ee, em);
  endtask

  initial begin
    int n;
    int pulses;
    bit seen;

    rst      = 1'b1;
    in_Valid = 1'b0;
    drive_ops(1'b0, 5'd0, 10'd0, 1'b0, 5'd0, 10'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst.ready", 32'(out_Ready), 32'd1);
    check("rst.valid", 32'(out_Valid), 32'd0);
    check_out("rst", 1'b0, 5'd0, 10'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 3.0 - 1.0 = 2.0, one align shift
    run_op("3m1", 1'b0, 5'b10000, 10'b1000000000, 1'b0, 5'b01111, 10'd0,
           1'b0, 5'b10000, 10'd0, 4);
    // 1.0 - 1.0 = +0
    run_op("1m1", 1'b0, 5'b01111, 10'd0, 1'b0, 5'b01111, 10'd0,
           1'b0, 5'd0, 10'd0, 3);
    // 1.0 - (-1.0) = 2.0 through the carry path
    run_op("1mn1", 1'b0, 5'b01111, 10'd0, 1'b1, 5'b01111, 10'd0,
           1'b0, 5'b10000, 10'd0, 3);
    // 1.5 - 1.25 = 0.25, two left shifts
    run_op("15m125", 1'b0, 5'b01111, 10'b1000000000, 1'b0, 5'b01111, 10'b0100000000,
           1'b0, 5'b01101, 10'd0, 5);
    // 1.0 - 2.0 = -1.0, operands swapped
    run_op("1m2", 1'b0, 5'b01111, 10'd0, 1'b0, 5'b10000, 10'd0,
           1'b1, 5'b01111, 10'd0, 5);
    // Exponent gap 16: align capped at 11, larger returned unchanged
    run_op("bigdiff", 1'b0, 5'b11000, 10'b0101010101, 1'b0, 5'b01000, 10'b1111111111,
           1'b0, 5'b11000, 10'b0101010101, 14);
    // Carry past exponent 30 saturates to EXP_MAX with zero mantissa
    run_op("ovf", 1'b0, 5'b11110, 10'b1111111111, 1'b1, 5'b11110, 10'b1111111111,
           1'b0, 5'b11111, 10'd0, 3);
    // Left shift at exponent 1 flushes to zero
    run_op("unf", 1'b0, 5'b00001, 10'b1000000000, 1'b0, 5'b00001, 10'd0,
           1'b0, 5'd0, 10'd0, 3);
    // Truncation of bits shifted out during alignment
    run_op("trunc", 1'b0, 5'b10001, 10'b0000000001, 1'b1, 5'b01111, 10'b0000000011,
           1'b0, 5'b10001, 10'b0100000001, 5);

    // in_Valid held high with different operands while busy
    drive_ops(1'b0, 5'b10000, 10'b1000000000, 1'b0, 5'b01111, 10'd0);
    in_Valid = 1'b1;
    @(posedge clk); #1;
    drive_ops(1'b1, 5'b00011, 10'b0000011111, 1'b0, 5'b11100, 10'b1110000000);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (out_Valid) seen = 1'b1;
    end
    in_Valid = 1'b0;
    check("busy.lat", 32'(n), 32'd4);
    check_out("busy", 1'b0, 5'b10000, 10'd0);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_Valid) pulses++;
    end
    check("busy.extra", 32'(pulses), 32'd0);

    // rst pulsed during ALIGN aborts the operation
    drive_ops(1'b0, 5'b11000, 10'b0101010101, 1'b0, 5'b01000, 10'b1111111111);
    in_Valid = 1'b1;
    @(posedge clk); #1;
    in_Valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("abort.busy", 32'(out_Ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort.ready", 32'(out_Ready), 32'd1);
    check("abort.valid", 32'(out_Valid), 32'd0);
    check_out("abort", 1'b0, 5'd0, 10'd0);
    run_op("postrst", 1'b0, 5'b10000, 10'b1000000000, 1'b0, 5'b01111, 10'd0,
           1'b0, 5'b10000, 10'd0, 4);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (out_Valid) pulses++;
    end
    check("abort.extra", 32'(pulses), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fsub_halfprecision_seq.md
FSUB_HALFPRECISION_SEQ -- requirements
Module: fsub_halfprecision_seq

Interface
REQ-001 clk  input  1  single clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_Valid  input  1  start request; accepted only when out_Ready=1.
REQ-004 in_Sign_1 / in_Exponent_1 / in_Mantissa_1  input  1 / [5:1] / [10:1]  operand A (minuend), half-precision fields.
REQ-005 in_Sign_2 / in_Exponent_2 / in_Mantissa_2  input  1 / [5:1] / [10:1]  operand B (subtrahend).
REQ-006 out_Ready  output  1  high in IDLE only.
REQ-007 out_Valid  output  1  one-cycle pulse when result is valid.
REQ-008 out_Sign / out_Exponent / out_Mantissa  output  1 / [5:1] / [10:1]  result A-B; held from DONE until next accept.

Function
REQ-009 Shall compute A-B as A+(-B): B sign inverted at capture; hidden bit 1 for every operand; no denormal/Inf/NaN handling; truncation, no rounding.
REQ-010 FSM states IDLE, ALIGN, ARITH, NORM, DONE; only one operation in flight.
REQ-011 IDLE & in_Valid: register operands, order them as larger (greater exponent; tie → greater mantissa; full tie → A) and smaller, load 11-bit mantissas {1,man}, load shift count = min(exp diff, 11); next ALIGN if count≠0 else ARITH.
REQ-012 in_Valid outside IDLE shall be ignored, with no effect on state or outputs.
REQ-013 ALIGN: smaller mantissa right-shifted 1 bit per cycle, zero-fill, count decremented; exit to ARITH in the cycle count reaches 0.
REQ-014 ARITH (1 cycle): 12-bit result; effective signs equal → larger+smaller; else larger−smaller (never negative); result sign = larger operand's effective sign; next NORM.
REQ-015 NORM, one action per cycle, priority order: result zero → out all zeros (sign 0), DONE; bit12 set → shift right 1, exp+1, DONE; bit11 set → DONE; else shift left 1, exp−1, stay.
REQ-016 Exponent overflow (exp+1 > 5'b11110) → out_Exponent 5'b11111, out_Mantissa 0, sign kept.
REQ-017 Exponent underflow (exp−1 would reach 0 during NORM) → flush to all zeros, DONE.
REQ-018 DONE: out_Valid=1 for exactly one cycle, outputs updated that cycle; next IDLE.
REQ-019 Latency from accept edge to out_Valid = 1 + align shifts + 1 + norm cycles; maximum bounded (≤ 26 cycles).

Reset
REQ-020 rst shall force IDLE; out_Ready=1, out_Valid=0, out_Sign=0, out_Exponent=0, out_Mantissa=0, all internal registers cleared.
REQ-021 rst asserted mid-operation shall abort with no out_Valid pulse; a new request is accepted in the first cycle after rst deasserts.

Structure
REQ-022 Shared package shall hold EXP_W=5, MAN_W=10, EXP_MAX=5'b11111, align cap 11, and the FSM state encoding.
REQ-023 One sub-module, fsub_mantissa_alu: combinational 12-bit add/subtract of two 11-bit magnitudes with op select; all sequencing stays in the top.

Verification
REQ-024 3.0−1.0 (0 10000 1000000000, 0 01111 0000000000) → out 0 10000 0000000000; out_Valid 4 cycles after accept.
REQ-025 1.0−1.0 → out all zeros, sign 0; 1.0−(−1.0) → 0 10000 0000000000 (carry path).
REQ-026 1.5−1.25 (0 01111 1000000000, 0 01111 0100000000) → 0 01101 0000000000 after 2 NORM left shifts.
REQ-027 1.0−2.0 → 1 01111 0000000000 (operand swap, negative result).
REQ-028 in_Valid held high during busy → ignored, single result; rst pulsed in ALIGN → no out_Valid, outputs zero, out_Ready=1 next cycle.
REQ-029 Exponent diff ≥ 12 (e.g. 0 11000 …, 0 01000 …) → larger operand returned unchanged, align count capped at 11.
